// File: rtl/rv32m_muldiv_unit.sv
// rtl/rv32m_muldiv_unit.sv - iterative RV32M multiply/divide execute unit
// One shift-add or restoring-divide step per cycle; divide-by-zero and signed overflow bypass iteration.
module rv32m_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_funct3,
    input  logic [WIDTH-1:0]      i_rs1_data,
    input  logic [WIDTH-1:0]      i_rs2_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t state, state_next;

    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [WIDTH-1:0]      opnd;
    logic [2*WIDTH-1:0]    acc;
    logic [CW-1:0]         cnt;
    logic                  sign_a, sign_b;

    logic                  accept, is_div, a_signed_in, b_signed_in, neg_a_in, neg_b_in;
    logic [WIDTH-1:0]      a_mag_in, b_mag_in, special_res;
    logic                  div_zero, div_ovf, special, last;
    logic [WIDTH:0]        mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]    mul_acc_next, div_acc_next, prod;
    logic [WIDTH-1:0]      mul_res, div_res, quo, rem;

    assign accept      = i_valid && (state == S_IDLE) && !i_flush;
    assign is_div      = i_funct3[2];
    assign a_signed_in = is_div ? !i_funct3[0] : (i_funct3[1:0] != 2'b11);
    assign b_signed_in = is_div ? !i_funct3[0] : !i_funct3[1];
    assign neg_a_in    = a_signed_in && i_rs1_data[WIDTH-1];
    assign neg_b_in    = b_signed_in && i_rs2_data[WIDTH-1];
    assign a_mag_in    = neg_a_in ? -i_rs1_data : i_rs1_data;
    assign b_mag_in    = neg_b_in ? -i_rs2_data : i_rs2_data;

    assign div_zero = is_div && (i_rs2_data == '0);
    assign div_ovf  = is_div && !i_funct3[0] && (i_rs1_data == {1'b1, {(WIDTH-1){1'b0}}})
                      && (i_rs2_data == {WIDTH{1'b1}});
    assign special  = div_zero || div_ovf;
    assign special_res = div_zero ? (i_funct3[1] ? i_rs1_data : {WIDTH{1'b1}})
                                  : (i_funct3[1] ? '0 : i_rs1_data);

    // Multiplier sits in acc's low half and is consumed LSB-first as the product shifts in.
    assign mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_acc_next = {mul_sum, acc[WIDTH-1:1]};
    assign prod         = (sign_a ^ sign_b) ? -mul_acc_next : mul_acc_next;
    assign mul_res      = (op_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

    // acc holds {remainder, dividend/quotient}; quotient bits enter at the bottom.
    assign div_shift    = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff     = div_shift - {1'b0, opnd};
    assign div_acc_next = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                          : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign quo          = div_acc_next[WIDTH-1:0];
    assign rem          = div_acc_next[2*WIDTH-1:WIDTH];
    assign div_res      = op_q[1] ? (sign_a ? -rem : rem)
                                  : ((sign_a ^ sign_b) ? -quo : quo);

    assign last    = (cnt == CW'(WIDTH-1));
    assign o_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = special ? S_DONE : (is_div ? S_DIV : S_MUL);
            S_MUL,
            S_DIV:   if (last) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        if (i_flush) state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            rd_q      <= '0;
            opnd      <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            o_rd_data <= '0;
            o_rd_addr <= '0;
        end else if (accept) begin
            op_q   <= i_funct3[1:0];
            rd_q   <= i_rd_addr;
            sign_a <= neg_a_in;
            sign_b <= neg_b_in;
            opnd   <= is_div ? b_mag_in : a_mag_in;
            acc    <= {{WIDTH{1'b0}}, is_div ? a_mag_in : b_mag_in};
            cnt    <= '0;
            if (special) begin
                o_rd_data <= special_res;
                o_rd_addr <= i_rd_addr;
            end
        end else if (!i_flush && (state == S_MUL || state == S_DIV)) begin
            acc <= (state == S_MUL) ? mul_acc_next : div_acc_next;
            cnt <= cnt + CW'(1);
            if (last) begin
                o_rd_data <= (state == S_MUL) ? mul_res : div_res;
                o_rd_addr <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb/tb_rv32m_muldiv_unit.sv - self-checking bench for rv32m_muldiv_unit
// Directed cases plus randomized operations against an arithmetic reference model.
module tb_rv32m_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_rs1_data = '0;
    logic [31:0] i_rs2_data = '0;
    logic [4:0]  i_rd_addr = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;

    int checks = 0;
    int errors = 0;

    rv32m_muldiv_unit #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct3(i_funct3), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_rd_addr(i_rd_addr), .i_flush(i_flush), .o_valid(o_valid),
        .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub;
        int ia, ib;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: model = 32'(sa * sb);
            3'd1: model = 32'((sa * sb) >> 32);
            3'd2: model = 32'((sa * ub) >> 32);
            3'd3: model = 32'((ua * ub) >> 32);
            3'd4: model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: model = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom % 6)
            0: pick_operand = 32'd0;
            1: pick_operand = 32'hFFFF_FFFF;
            2: pick_operand = 32'h8000_0000;
            3: pick_operand = $urandom % 16;
            default: pick_operand = $urandom;
        endcase
    endfunction

    // Called #1 after a clock edge; the following edge is the accept edge.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp_data;
        int exp_lat, lat;
        exp_data = model(f, a, b);
        exp_lat  = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 32;
        i_valid = 1'b1; i_funct3 = f; i_rs1_data = a; i_rs2_data = b; i_rd_addr = rd;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("ready_low_after_accept", o_ready, 0);
        lat = 0;
        while (!o_valid && lat < 40) begin
            // Busy-time noise on every input must not disturb the latched operation.
            i_valid    = 1'($urandom);
            i_funct3   = 3'($urandom);
            i_rs1_data = $urandom;
            i_rs2_data = $urandom;
            i_rd_addr  = 5'($urandom);
            if (lat > 0) check("ready_low_busy", o_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        i_valid = 1'b0;
        check("latency", lat, exp_lat);
        check("rd_data", o_rd_data, exp_data);
        check("rd_addr", o_rd_addr, rd);
        check("ready_low_done", o_ready, 0);
        @(posedge clk); #1;
        check("valid_one_cycle", o_valid, 0);
        check("ready_after_done", o_ready, 1);
    endtask

    initial begin
        logic [31:0] held;
        int seen;
        #12;
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_rd_data, 0);
        check("rst_addr", o_rd_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8);
        run_op(3'd4, 32'd5, 32'd0, 5'd9);
        run_op(3'd7, 32'd5, 32'd0, 5'd10);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);

        // Flush during iteration 10, with a same-cycle request that must not be accepted.
        held = o_rd_data;
        i_valid = 1'b1; i_funct3 = 3'd0; i_rs1_data = 32'd9; i_rs2_data = 32'd9; i_rd_addr = 5'd12;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        i_flush = 1'b1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        check("flush_ready", o_ready, 1);
        check("flush_valid", o_valid, 0);
        check("flush_data_held", o_rd_data, held);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        check("flush_no_valid", seen, 0);
        run_op(3'd0, 32'd3, 32'd4, 5'd13);

        for (int i = 0; i < 60; i++)
            run_op(3'($urandom), pick_operand(), pick_operand(), 5'($urandom));

        // Asynchronous reset in the middle of a divide.
        i_valid = 1'b1; i_funct3 = 3'd5; i_rs1_data = 32'd1000; i_rs2_data = 32'd7; i_rd_addr = 5'd14;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_data", o_rd_data, 0);
        check("midrst_ready", o_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        check("midrst_no_valid", seen, 0);
        run_op(3'd5, 32'd1000, 32'd7, 5'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
